// File: rtl/organ_note_sequencer.sv
// Organ note sequencer: turns a 3-bit note index (C5..C6 at 50 MHz) into the
// terminal count for the 32-bit arbitrary clock divider and gates the tone.
// Manual mode follows the switches. Auto mode plays the scale with timed
// note and gap durations, optional descending order and optional looping.
module organ_note_sequencer #(
   parameter int unsigned NOTE_TICKS = 25000000,
   parameter int unsigned GAP_TICKS  = 2500000
) (
   input  logic        inclk,
   input  logic        Reset,
   input  logic        manual_en,
   input  logic [2:0]  manual_note,
   input  logic        manual_key,
   input  logic        start,
   input  logic        stop,
   input  logic        dir,
   input  logic        loop,
   output logic [31:0] div_clk_count,
   output logic        tone_en,
   output logic [2:0]  note_idx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   // The counter runs 0..LAST inclusive, so each phase lasts exactly TICKS cycles.
   localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
   localparam logic [31:0] GAP_LAST  = (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;
   localparam bit          HAS_GAP   = (GAP_TICKS > 0);

   state_t      state_q, state_d;
   logic [2:0]  note_q, note_d;
   logic [31:0] cnt_q, cnt_d;
   logic        dir_q, dir_d;
   logic [31:0] count_q, count_d;
   logic        tone_q, tone_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        final_note;
   state_t      adv_state;
   logic [2:0]  adv_note;

   // Divider terminal counts for the eight notes of the scale.
   function automatic logic [31:0] note_count(input logic [2:0] idx);
      logic [31:0] c;
      unique case (idx)
         3'd0: c = 32'd47801;
         3'd1: c = 32'd42589;
         3'd2: c = 32'd37936;
         3'd3: c = 32'd35817;
         3'd4: c = 32'd31928;
         3'd5: c = 32'd28409;
         3'd6: c = 32'd25329;
         default: c = 32'd23901;
      endcase
      return c;
   endfunction

   // Where a finished note leads: next note, wrap to the start note, or DONE.
   always_comb begin
      final_note = dir_q ? (note_q == 3'd0) : (note_q == 3'd7);
      adv_state  = PLAY;
      adv_note   = note_q;
      if (!final_note) begin
         adv_note = dir_q ? (note_q - 3'd1) : (note_q + 3'd1);
      end else if (loop) begin
         adv_note = dir_q ? 3'd7 : 3'd0;
      end else begin
         adv_state = DONE;
      end
   end

   // Next-state, note, counter and registered-output computation.
   always_comb begin
      state_d = state_q;
      note_d  = note_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      tone_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (manual_en) begin
               note_d = manual_note;
               tone_d = manual_key;
            end else if (start) begin
               state_d = PLAY;
               note_d  = dir ? 3'd7 : 3'd0;
               dir_d   = dir;
               cnt_d   = 32'd0;
            end
         end
         PLAY: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cnt_q >= NOTE_LAST) begin
               cnt_d = 32'd0;
               if (HAS_GAP) begin
                  state_d = GAP;
               end else begin
                  state_d = adv_state;
                  note_d  = adv_note;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         GAP: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cnt_q >= GAP_LAST) begin
               cnt_d   = 32'd0;
               state_d = adv_state;
               note_d  = adv_note;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_d == PLAY) begin
         tone_d = 1'b1;
      end
      busy_d  = (state_d == PLAY) || (state_d == GAP);
      done_d  = (state_d == DONE);
      count_d = note_count(note_d);
   end

   // State and output registers; reset silences the tone and selects note 0.
   always_ff @(posedge inclk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         note_q  <= 3'd0;
         cnt_q   <= 32'd0;
         dir_q   <= 1'b0;
         count_q <= 32'd47801;
         tone_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         note_q  <= note_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         count_q <= count_d;
         tone_q  <= tone_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign div_clk_count = count_q;
   assign tone_en       = tone_q;
   assign note_idx      = note_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_organ_note_sequencer.sv
// Testbench for organ_note_sequencer: directed vectors for the timing corners
// plus randomized stimulus compared against a timeline model of the sequence.
module tb_organ_note_sequencer;

   localparam int N = 4;
   localparam int G = 2;
   localparam int P = N + G;

   logic        inclk;
   logic        Reset;
   logic        manual_en;
   logic [2:0]  manual_note;
   logic        manual_key;
   logic        start;
   logic        stop;
   logic        dir;
   logic        loop;

   logic [31:0] div_clk_count;
   logic        tone_en;
   logic [2:0]  note_idx;
   logic        busy;
   logic        done;

   logic [31:0] d0_count;
   logic        d0_tone;
   logic [2:0]  d0_note;
   logic        d0_busy;
   logic        d0_done;

   int nCompared;
   int nMismatch;

   logic [31:0] noteTable [8];

   // Timeline model: a sequence is described by elapsed cycles since its start.
   bit         mActive;
   bit         mInDone;
   int         mE;
   bit         mDir;
   logic [2:0] mNote;
   bit         mTone;
   bit         mBusy;
   bit         mDone;

   typedef struct {
      logic [2:0]  note;
      logic        key;
      logic [31:0] expCount;
      logic        expTone;
   } manualVec_t;

   manualVec_t manVecs [6];

   organ_note_sequencer #(.NOTE_TICKS(N), .GAP_TICKS(G)) dut (
      .inclk(inclk), .Reset(Reset), .manual_en(manual_en),
      .manual_note(manual_note), .manual_key(manual_key),
      .start(start), .stop(stop), .dir(dir), .loop(loop),
      .div_clk_count(div_clk_count), .tone_en(tone_en), .note_idx(note_idx),
      .busy(busy), .done(done)
   );

   organ_note_sequencer #(.NOTE_TICKS(N), .GAP_TICKS(0)) dut0 (
      .inclk(inclk), .Reset(Reset), .manual_en(manual_en),
      .manual_note(manual_note), .manual_key(manual_key),
      .start(start), .stop(stop), .dir(dir), .loop(loop),
      .div_clk_count(d0_count), .tone_en(d0_tone), .note_idx(d0_note),
      .busy(d0_busy), .done(d0_done)
   );

   initial inclk = 1'b0;
   always #5 inclk = ~inclk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset;
      mActive = 0; mInDone = 0; mE = 0; mDir = 0;
      mNote = 3'd0; mTone = 0; mBusy = 0; mDone = 0;
   endtask

   task automatic modelFromElapsed;
      int pos;
      int phase;
      pos   = (mE - 1) / P;
      phase = (mE - 1) % P;
      mNote = mDir ? 3'(7 - pos) : 3'(pos);
      mTone = (phase < N);
      mBusy = 1;
   endtask

   task automatic modelStep;
      mDone = 0;
      if (Reset) begin
         modelReset();
      end else if (mInDone) begin
         mInDone = 0; mTone = 0; mBusy = 0;
      end else if (mActive) begin
         if (stop) begin
            mActive = 0; mTone = 0; mBusy = 0;
         end else begin
            mE++;
            if (mE > 8 * P) begin
               if (loop) begin
                  mE = 1;
               end else begin
                  mActive = 0; mInDone = 1; mDone = 1; mTone = 0; mBusy = 0;
               end
            end
            if (mActive) modelFromElapsed();
         end
      end else if (manual_en) begin
         mNote = manual_note;
         mTone = manual_key;
      end else begin
         mTone = 0;
         if (start) begin
            mActive = 1; mDir = dir; mE = 1;
            modelFromElapsed();
         end
      end
   endtask

   task automatic checkModel;
      checkOutput("model.note_idx", 32'(note_idx), 32'(mNote));
      checkOutput("model.div_clk_count", div_clk_count, noteTable[mNote]);
      checkOutput("model.tone_en", 32'(tone_en), 32'(mTone));
      checkOutput("model.busy", 32'(busy), 32'(mBusy));
      checkOutput("model.done", 32'(done), 32'(mDone));
   endtask

   task automatic tick;
      @(posedge inclk);
      modelStep();
      #1;
      checkModel();
   endtask

   task automatic applyStimulus(input logic st, input logic sp);
      start = st;
      stop  = sp;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic doReset;
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   initial begin
      nCompared = 0;
      nMismatch = 0;
      noteTable[0] = 32'd47801; noteTable[1] = 32'd42589;
      noteTable[2] = 32'd37936; noteTable[3] = 32'd35817;
      noteTable[4] = 32'd31928; noteTable[5] = 32'd28409;
      noteTable[6] = 32'd25329; noteTable[7] = 32'd23901;
      manVecs[0] = '{3'd5, 1'b1, 32'd28409, 1'b1};
      manVecs[1] = '{3'd5, 1'b0, 32'd28409, 1'b0};
      manVecs[2] = '{3'd0, 1'b1, 32'd47801, 1'b1};
      manVecs[3] = '{3'd7, 1'b1, 32'd23901, 1'b1};
      manVecs[4] = '{3'd3, 1'b0, 32'd35817, 1'b0};
      manVecs[5] = '{3'd2, 1'b1, 32'd37936, 1'b1};
      modelReset();
      manual_en = 0; manual_note = 0; manual_key = 0;
      start = 0; stop = 0; dir = 0; loop = 0;
      Reset = 1'b1;
      #2;
      doReset();
      checkOutput("reset.div_clk_count", div_clk_count, 32'd47801);
      checkOutput("reset.tone_en", 32'(tone_en), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);

      // Manual mode vectors, one-cycle latency.
      manual_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         manual_note = manVecs[i].note;
         manual_key  = manVecs[i].key;
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("manual[%0d].count", i), div_clk_count, manVecs[i].expCount);
         checkOutput($sformatf("manual[%0d].tone", i), 32'(tone_en), 32'(manVecs[i].expTone));
         checkOutput($sformatf("manual[%0d].busy", i), 32'(busy), 32'd0);
      end
      manual_en = 1'b0;
      manual_key = 1'b0;
      applyStimulus(1'b0, 1'b0);
      checkOutput("auto_idle.tone", 32'(tone_en), 32'd0);

      // Ascending, no loop: start sampled at cycle 0.
      doReset();
      dir = 0; loop = 0;
      applyStimulus(1'b1, 1'b0);
      for (int t = 1; t <= 50; t++) begin
         if (t == 1) begin
            checkOutput("asc.t1.tone", 32'(tone_en), 32'd1);
            checkOutput("asc.t1.count", div_clk_count, 32'd47801);
            checkOutput("asc.t1.busy", 32'(busy), 32'd1);
         end
         if (t == 4) checkOutput("asc.t4.tone", 32'(tone_en), 32'd1);
         if (t == 5) checkOutput("asc.t5.tone", 32'(tone_en), 32'd0);
         if (t == 7) begin
            checkOutput("asc.t7.count", div_clk_count, 32'd42589);
            checkOutput("asc.t7.tone", 32'(tone_en), 32'd1);
         end
         if (t == 48) checkOutput("asc.t48.busy", 32'(busy), 32'd1);
         if (t == 49) begin
            checkOutput("asc.t49.done", 32'(done), 32'd1);
            checkOutput("asc.t49.busy", 32'(busy), 32'd0);
            checkOutput("asc.t49.note", 32'(note_idx), 32'd7);
         end
         if (t == 50) checkOutput("asc.t50.done", 32'(done), 32'd0);
         // GAP_TICKS=0 instance runs notes back to back.
         if (t <= 32) begin
            checkOutput("nogap.tone", 32'(d0_tone), 32'd1);
            checkOutput("nogap.note", 32'(d0_note), 32'((t - 1) / 4));
         end
         if (t == 33) checkOutput("nogap.done", 32'(d0_done), 32'd1);
         if (t < 50) tick();
      end

      // Descending with loop, then drop loop during the second pass.
      doReset();
      dir = 1; loop = 1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("desc.t1.note", 32'(note_idx), 32'd7);
      for (int t = 2; t <= 98; t++) begin
         tick();
         if (t == 48) checkOutput("desc.t48.note", 32'(note_idx), 32'd0);
         if (t == 49) begin
            checkOutput("desc.t49.note", 32'(note_idx), 32'd7);
            checkOutput("desc.t49.tone", 32'(tone_en), 32'd1);
            checkOutput("desc.t49.done", 32'(done), 32'd0);
            loop = 0;
         end
         if (t == 97) checkOutput("desc.t97.done", 32'(done), 32'd1);
      end

      // Stop and start together in the gap of note 2, then restart.
      doReset();
      dir = 0; loop = 0;
      applyStimulus(1'b1, 1'b0);
      for (int t = 2; t <= 17; t++) tick();
      checkOutput("stop.gap.tone", 32'(tone_en), 32'd0);
      checkOutput("stop.gap.note", 32'(note_idx), 32'd2);
      applyStimulus(1'b1, 1'b1);
      checkOutput("stop.busy", 32'(busy), 32'd0);
      checkOutput("stop.note", 32'(note_idx), 32'd2);
      checkOutput("stop.done", 32'(done), 32'd0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("restart.note", 32'(note_idx), 32'd0);
      checkOutput("restart.tone", 32'(tone_en), 32'd1);

      // Asynchronous reset while note 3 is playing.
      doReset();
      applyStimulus(1'b1, 1'b0);
      for (int t = 2; t <= 19; t++) tick();
      checkOutput("prereset.note", 32'(note_idx), 32'd3);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("async_reset.tone", 32'(tone_en), 32'd0);
      checkOutput("async_reset.note", 32'(note_idx), 32'd0);
      checkOutput("async_reset.count", div_clk_count, 32'd47801);
      checkOutput("async_reset.busy", 32'(busy), 32'd0);
      tick();
      Reset = 1'b0;
      tick();

      // Randomized traffic checked against the timeline model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) manual_en = ~manual_en;
         manual_note = 3'($urandom_range(0, 7));
         manual_key  = 1'($urandom_range(0, 1));
         dir         = 1'($urandom_range(0, 1));
         loop        = ($urandom_range(0, 3) == 0);
         applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/organ_note_sequencer.md
Name: organ_note_sequencer

Overview:
Controller for the organ tone path's 32-bit arbitrary clock divider. It converts an 8-entry note index (C5..C6 at 50 MHz) into the divider's div_clk_count value and gates the speaker tone. In manual mode the note follows the switches. In auto mode a state machine plays the scale ascending or descending, with timed note and gap durations and an optional loop.

Parameters:
NOTE_TICKS, 25000000, inclk cycles each note sounds (>=1)
GAP_TICKS, 2500000, inclk cycles of silence after each note (0 = no gap)

Ports:
inclk  input  1  system clock, 50 MHz
Reset  input  1  asynchronous, active-high reset
manual_en  input  1  1 = manual mode, 0 = auto mode
manual_note  input  3  note index in manual mode
manual_key  input  1  tone gate in manual mode
start  input  1  single-cycle pulse; starts an auto sequence
stop  input  1  single-cycle pulse; aborts an auto sequence
dir  input  1  0 = ascending, 1 = descending; sampled on accepted start
loop  input  1  1 = repeat the sequence indefinitely; sampled every sequence end
div_clk_count  output  32  divider terminal count, registered
tone_en  output  1  gate for the divided clock to the audio path, registered
note_idx  output  3  current note index, registered
busy  output  1  1 in PLAY or GAP
done  output  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Note table (idx -> div_clk_count):
  - 0 -> 47801, 1 -> 42589, 2 -> 37936, 3 -> 35817
  - 4 -> 31928, 5 -> 28409, 6 -> 25329, 7 -> 23901
- div_clk_count always equals table[note_idx]. It is registered together with note_idx, with no skew.
- Reset (asynchronous, any state):
  - state IDLE, note_idx = 0, div_clk_count = 47801
  - tone_en = 0, busy = 0, done = 0
  - internal tick counter = 0, latched dir = 0
- States: IDLE, PLAY, GAP, DONE.
- IDLE, manual_en = 1:
  - each cycle, note_idx <= manual_note and tone_en <= manual_key (1-cycle latency)
  - start is ignored
- IDLE, manual_en = 0:
  - tone_en <= 0
  - on start: go to PLAY next cycle, note_idx <= (dir ? 7 : 0), latch dir, counter <= 0
- PLAY:
  - tone_en = 1 for exactly NOTE_TICKS cycles
  - on the last cycle: if GAP_TICKS > 0 go to GAP, else advance the note directly
- GAP:
  - tone_en = 0 for exactly GAP_TICKS cycles, note_idx held, then advance
- Advance:
  - If the current note is not the final one (7 ascending, 0 descending), note_idx steps +1/-1, go to PLAY, counter cleared.
  - If it is final and loop = 1, note_idx returns to the start note and goes to PLAY. No done pulse.
  - If it is final and loop = 0, go to DONE.
- DONE: done = 1 and busy = 0 for one cycle, tone_en = 0, then IDLE. note_idx holds the final note.
- Period per note: NOTE_TICKS + GAP_TICKS cycles. No dead cycles between notes.
- stop in PLAY, GAP or DONE:
  - next cycle IDLE, tone_en = 0, busy = 0
  - no done pulse; note_idx holds its current value
- Simultaneous events:
  - stop has priority over start and over advance
  - start while busy is ignored
  - manual_en asserted while busy is ignored until IDLE
- Tick counter is 32 bits, compared with >= against the terminal count, so it never wraps.
- All outputs are registered.

Test Plan:
- Override NOTE_TICKS=4, GAP_TICKS=2 for all scenarios.
- Reset mid-PLAY (note_idx=3) -> same cycle: tone_en=0, note_idx=0, div_clk_count=47801, busy=0, state IDLE.
- Manual mode: manual_note=5, manual_key=1 -> next cycle div_clk_count=28409, tone_en=1. Then manual_key=0 -> tone_en=0 next cycle.
- Auto ascending: dir=0, loop=0, start pulse at cycle 0:
  - cycles 1-4 tone_en=1 with idx 0 (47801), cycles 5-6 tone_en=0
  - idx 1 (42589) at cycle 7, and so on
  - idx 7 ends at cycle 48; done=1 at cycle 49; IDLE at cycle 50
- Auto descending with loop=1 -> sequence 7..0, then idx 7 again at cycle 49 with no done pulse. Drop loop -> done after the second pass.
- stop and start pulsed together in GAP of idx 2 -> next cycle IDLE, busy=0, tone_en=0, no done. A start in the following cycle restarts from idx 0.
- GAP_TICKS=0 -> consecutive notes with tone_en continuously 1 and note_idx changing every 4 cycles.
